reg_write_queue: RTL and testbench

- Write-request buffer that sits directly upstream of the 8 x 32-bit enable-register bank.
- Accepts (address, data) write requests over a valid/ready handshake and holds them in a small FIFO.
- Drains at most one request per clock: decodes the address to a one-hot enable vector and presents the data on the bank's shared data bus.
- Lets producers issue bursts without tracking the bank's single-write-per-cycle limit.

---
 rtl/reg_write_queue.sv | 115 +++++++++++
 tb/tb_reg_write_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_queue.sv
// reg_write_queue: FIFO of (addr, data) writes feeding the enable-register bank.
// Define REG_WRITE_QUEUE_MERGE_EN to fold same-address pushes into the tail entry.
module reg_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     stall,
  output logic [(2**ADDR_W)-1:0]   en,
  output logic [DATA_W-1:0]        d_in,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);

  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  wp_q, wp_d;
  logic [PTR_W-1:0]  rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   en_q, en_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic push;
  logic pop;
  logic merge;
  logic alloc;

  assign wr_ready = (cnt_q != CNT_W'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = !stall && (cnt_q != '0);

`ifdef REG_WRITE_QUEUE_MERGE_EN
  logic [PTR_W-1:0] tail;
  assign tail  = wp_q - 1'b1;
  // A lone entry that is leaving this edge cannot absorb the write.
  assign merge = push && (cnt_q != '0)
              && (addr_q[tail] == wr_addr)
              && !(pop && (cnt_q == CNT_W'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push && !merge;

  // Next-state: pointers, occupancy and the registered bank drive.
  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    en_d   = '0;
    dout_d = dout_q;
    if (alloc) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d   = rp_q + 1'b1;
      dout_d = data_q[rp_q];
      for (int i = 0; i < NREG; i++) begin
        en_d[i] = (addr_q[rp_q] == ADDR_W'(i));
      end
    end
    if (alloc && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!alloc && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Entry storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wp_q] <= wr_addr;
      data_q[wp_q] <= wr_data;
    end
`ifdef REG_WRITE_QUEUE_MERGE_EN
    else if (merge) begin
      data_q[tail] <= wr_data;
    end
`endif
  end

  // Control state with synchronous flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      en_q   <= '0;
      dout_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      dout_q <= dout_d;
    end
  end

  assign en    = en_q;
  assign d_in  = dout_q;
  assign count = cnt_q;
  assign busy  = (cnt_q != '0) || (en_q != '0);

endmodule

// File: tb/tb_reg_write_queue.sv
// tb_reg_write_queue: scoreboard bench for reg_write_queue.
// Stimulus queues expected writes; a negedge monitor checks each enable pulse.
module tb_reg_write_queue;

`ifdef REG_WRITE_QUEUE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  typedef struct {
    logic [2:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic [7:0]  en;
  logic [31:0] d_in;
  logic [2:0]  count;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   pulse_log[$];

  reg_write_queue #(
    .DEPTH(4),
    .DATA_W(32),
    .ADDR_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .stall(stall),
    .en(en),
    .d_in(d_in),
    .count(count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("en_onehot0", 64'($onehot0(en)), 64'd1);
    if (en !== 8'h00) begin
      pulse_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_en: en=%0h d_in=%0h, required no pulse",
                 en, d_in);
      end else begin
        e = exp_q.pop_front();
        chk("mon_en", 64'(en), 64'(8'h01 << e.a));
        chk("mon_d_in", 64'(d_in), 64'(e.d));
      end
    end
  end

  task automatic push(input logic [2:0] a, input logic [31:0] d,
                      input bit mrg, output int waits);
    bit   acc;
    exp_t e;
    waits    = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    do begin
      acc = wr_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!acc && waits < 50);
    wr_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: addr=%0d not accepted, required accept", a);
    end else if (mrg && exp_q.size() > 0) begin
      e = exp_q.pop_back();
      e.d = d;
      exp_q.push_back(e);
    end else begin
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    stall    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ready", 64'(wr_ready), 64'd1);
      chk("rst_en", 64'(en), 64'd0);
      chk("rst_d_in", 64'(d_in), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
    end

    @(posedge clk);
    #1;
    push(3'd3, 32'hDEADBEEF, 1'b0, w);
    chk("single_e0_en", 64'(en), 64'd0);
    chk("single_e0_count", 64'(count), 64'd1);
    @(posedge clk);
    #1;
    chk("single_e1_en", 64'(en), 64'h08);
    chk("single_e1_d_in", 64'(d_in), 64'hDEADBEEF);
    chk("single_e1_count", 64'(count), 64'd0);
    @(posedge clk);
    #1;
    chk("single_e2_en", 64'(en), 64'd0);
    chk("single_e2_d_in", 64'(d_in), 64'hDEADBEEF);
    chk("single_e2_busy", 64'(busy), 64'd0);

    pulse_log.delete();
    for (int a = 0; a < 6; a++) begin
      push(3'(a), 32'h100 + 32'(a), 1'b0, w);
      chk("burst_wait", 64'(w), 64'd1);
    end
    drain();
    chk("burst_pulses", 64'(pulse_log.size()), 64'd6);
    chk("burst_gapless", 64'(pulse_log[5] - pulse_log[0]), 64'd5);

    stall = 1'b1;
    push(3'd1, 32'h401, 1'b0, w);
    push(3'd6, 32'h406, 1'b0, w);
    push(3'd7, 32'h407, 1'b0, w);
    push(3'd0, 32'h400, 1'b0, w);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(wr_ready), 64'd0);
    chk("full_en", 64'(en), 64'd0);
    @(posedge clk);
    #1;
    chk("stall_count", 64'(count), 64'd4);
    chk("stall_en", 64'(en), 64'd0);
    pulse_log.delete();
    stall = 1'b0;
    push(3'd5, 32'h777, 1'b0, w);
    chk("full_reuse_wait", 64'(w), 64'd2);
    chk("full_reuse_count", 64'(count), 64'd3);
    drain();
    chk("stall_pulses", 64'(pulse_log.size()), 64'd5);
    chk("stall_gapless", 64'(pulse_log[4] - pulse_log[0]), 64'd4);

    stall = 1'b1;
    push(3'd2, 32'h502, 1'b0, w);
    push(3'd3, 32'h503, 1'b0, w);
    push(3'd4, 32'h504, 1'b0, w);
    chk("pre_rst_count", 64'(count), 64'd3);
    reset = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_en", 64'(en), 64'd0);
    chk("flush_d_in", 64'(d_in), 64'd0);
    chk("flush_ready", 64'(wr_ready), 64'd1);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_flush_en", 64'(en), 64'd0);
      chk("post_flush_busy", 64'(busy), 64'd0);
    end

    @(posedge clk);
    #1;
    stall = 1'b1;
    push(3'd2, 32'hAAAA_0001, 1'b0, w);
    push(3'd2, 32'hBBBB_0002, MERGE, w);
    chk("merge_count", 64'(count), MERGE ? 64'd1 : 64'd2);
    pulse_log.delete();
    stall = 1'b0;
    drain();
    chk("merge_pulses", 64'(pulse_log.size()), MERGE ? 64'd1 : 64'd2);
    chk("merge_d_in", 64'(d_in), 64'hBBBB_0002);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
